// File: rtl/restoring_divider.sv
// restoring_divider: multi-cycle unsigned divider, one quotient bit per cycle, valid/ready on both sides
module restoring_divider #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);
    localparam int CW = $clog2(WIDTH);
    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
    state_t           state_q, state_d;
    logic [WIDTH-1:0] q_q, q_d, r_q, r_d, d_q, d_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             dbz_q, dbz_d, out_valid_q, out_valid_d;
    logic [WIDTH:0]   s, t;
    always_comb begin
        s           = {r_q, q_q[WIDTH-1]};
        t           = s - {1'b0, d_q};
        state_d     = state_q;
        q_d         = q_q;
        r_d         = r_q;
        d_d         = d_q;
        cnt_d       = cnt_q;
        dbz_d       = dbz_q;
        out_valid_d = 1'b0;
        case (state_q)
            IDLE: if (in_valid) begin
                d_d     = divisor;
                cnt_d   = CW'(WIDTH - 1);
                dbz_d   = divisor == '0;
                q_d     = dbz_d ? '1 : dividend;
                r_d     = dbz_d ? dividend : '0;
                state_d = dbz_d ? DONE : CALC;
            end
            CALC: begin
                r_d         = t[WIDTH] ? s[WIDTH-1:0] : t[WIDTH-1:0];
                q_d         = {q_q[WIDTH-2:0], ~t[WIDTH]};
                cnt_d       = cnt_q - 1'b1;
                out_valid_d = cnt_q == '0;
                state_d     = cnt_q == '0 ? DONE : CALC;
            end
            DONE: begin
                // zero-divisor results spend one cycle in DONE before out_valid rises
                out_valid_d = ~(out_valid_q & out_ready);
                state_d     = out_valid_q & out_ready ? IDLE : DONE;
                dbz_d       = out_valid_q & out_ready ? 1'b0 : dbz_q;
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            q_q         <= '0;
            r_q         <= '0;
            d_q         <= '0;
            cnt_q       <= '0;
            dbz_q       <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            q_q         <= q_d;
            r_q         <= r_d;
            d_q         <= d_d;
            cnt_q       <= cnt_d;
            dbz_q       <= dbz_d;
            out_valid_q <= out_valid_d;
        end
    end
    assign in_ready    = state_q == IDLE;
    assign out_valid   = out_valid_q;
    assign quotient    = q_q;
    assign remainder   = r_q;
    assign div_by_zero = dbz_q;
endmodule
